vic_addr_gen: RTL
=================

// Module: vic_addr_gen
// PURPOSE
// Address-side initiator for every VIC data-bus read: c/g/p/s/refresh/idle.
// Computes the 14-bit VIC address for the current half-cycle and registers it on ado.
// Addresses on ado are stable before phi_phase_start_dav, when the data-side capture samples dbi.
// Owns the DRAM refresh counter and the address-bus output enable.
// PARAMETERS
// REF_INIT   8'hFF     refresh counter load value at start of frame
// IDLE_ADDR  14'h3FFF  address driven in idle/unused accesses
// PORTS
// clk_dot4x            in   1   4x dot clock
// rst                  in   1   synchronous, active-high reset
// phi_phase_start_as   in   1   1-clk strobe: address setup point of current half-cycle
// phi_phase_start_0    in   1   1-clk strobe: first dot4x tick of half-cycle
// clk_phi              in   1   phi level (1 = high/CPU-side half)
// aec                  in   1   0 = VIC owns bus in high phase
// cycle_type           in   4   access type (VIC_* encodings, common.vh)
// cycle_num            in   7   cycle within raster line
// raster_line          in   9   current raster line
// sprite_cnt           in   3   sprite index of current p/s access
// vc                   in   10  video counter
// rc                   in   3   row counter
// vm                   in   4   video matrix base ($D018[7:4])
// cb                   in   3   char/bitmap base ($D018[3:1])
// ecm, bmm, idle       in   1   mode bits / idle state
// char_next            in   12  char code for current g-access (bits 7:0 used)
// sprite_ptr_i         in   64  8 flattened pointers, sprite 0 in [63:56]
// sprite_mc_i          in   48  8 flattened 6-bit MC values, sprite 0 in [47:42]
// ado                  out  14  registered VIC address
// ado_oe               out  1   1 = VIC drives address bus this half-cycle
// ref_cnt              out  8   refresh counter (debug/readback)
// BEHAVIOUR
// - Reset: ado=IDLE_ADDR, ado_oe=0, ref_cnt=REF_INIT. Reset mid-cycle overrides any strobe.
// - Address mux evaluated combinationally; ado loaded on clk following phi_phase_start_as (1 clk
//   latency), held until next strobe. No strobe -> ado holds.
// - VIC_HRC/VIC_HGC/VIC_HRX/VIC_HGI (c-access): {vm,vc}. HRX/HGI still drive address (cache cycle).
// - VIC_LG (g-access): idle=1 -> IDLE_ADDR. Else bmm=1 -> {cb[2],vc,rc};
//   bmm=0 -> {cb,char_next[7:0],rc}. ecm=1 then forces ado[10:9]=0 (incl. idle: 14'h39FF).
// - VIC_LP (p-access): {vm,7'h7F,sprite_cnt}.
// - VIC_HS1/VIC_LS2/VIC_HS3 (s-access): {sprite_ptr[sprite_cnt], sprite_mc[sprite_cnt]}.
//   MC incremented by vic_sprites between the three accesses; this block only reads it.
// - VIC_LR (refresh): {6'h3F, ref_cnt}; ref_cnt decrements by 1 (8-bit wrap $00->$FF) on the
//   same clk ado loads.
// - VIC_LI and all other types: IDLE_ADDR.
// - ref_cnt loads REF_INIT when raster_line==0 && cycle_num==0 && phi_phase_start_0.
//   Load and decrement coincident -> load wins.
// - ado_oe: registered at phi_phase_start_as. clk_phi=0 -> 1; clk_phi=1 -> !aec.
// - sprite_cnt outside s/p types ignored; mode bits sampled only at strobe clk
//   (mid-half-cycle changes don't move ado).
// TESTING
// - rst pulse mid-line -> ado=14'h3FFF, ado_oe=0, ref_cnt=8'hFF next clk.
// - HRC, vm=4'h1, vc=10'h028 -> ado=14'h0428 one clk after strobe.
// - LG text, cb=3'b010, char=8'h41, rc=5 -> ado=14'h120D; then ecm=1 -> 14'h100D;
//   then idle=1, ecm=1 -> 14'h39FF.
// - LG bitmap, cb=3'b100, vc=10'h3E7, rc=7 -> ado=14'h3F3F.
// - LP sprite 3, vm=4'h1 -> 14'h07FB; HS1/LS2/HS3 with ptr3=8'h80, mc=0,1,2 -> 14'h2000,2001,2002.
// - Line 0 cycle 0: 5 LR cycles -> ado 14'h3FFF,3FFE,...,3FFB; ref_cnt=8'hFA.
//   ref_cnt=0 then LR -> ado 14'h3F00, ref_cnt=8'hFF.
// - High phase aec=1 -> ado_oe=0; aec=0 -> 1; low phase always 1.

Source files
------------

// File: rtl/vic_addr_gen.sv
// VIC address-side initiator: muxes the 14-bit bus address for c/g/p/s/refresh/idle
// accesses, registers it at the address setup strobe, and owns the DRAM refresh counter.
module vic_addr_gen #(
  parameter logic [7:0]  REF_INIT  = 8'hFF,
  parameter logic [13:0] IDLE_ADDR = 14'h3FFF
) (
  input  logic        clk_dot4x,
  input  logic        rst,
  input  logic        phi_phase_start_as,
  input  logic        phi_phase_start_0,
  input  logic        clk_phi,
  input  logic        aec,
  input  logic [3:0]  cycle_type,
  input  logic [6:0]  cycle_num,
  input  logic [8:0]  raster_line,
  input  logic [2:0]  sprite_cnt,
  input  logic [9:0]  vc,
  input  logic [2:0]  rc,
  input  logic [3:0]  vm,
  input  logic [2:0]  cb,
  input  logic        ecm,
  input  logic        bmm,
  input  logic        idle,
  input  logic [11:0] char_next,
  input  logic [63:0] sprite_ptr_i,
  input  logic [47:0] sprite_mc_i,
  output logic [13:0] ado,
  output logic        ado_oe,
  output logic [7:0]  ref_cnt
);

  localparam logic [3:0] VIC_LP  = 4'd0;
  localparam logic [3:0] VIC_LS2 = 4'd2;
  localparam logic [3:0] VIC_LR  = 4'd3;
  localparam logic [3:0] VIC_LG  = 4'd4;
  localparam logic [3:0] VIC_HS1 = 4'd5;
  localparam logic [3:0] VIC_HS3 = 4'd8;
  localparam logic [3:0] VIC_HRC = 4'd9;
  localparam logic [3:0] VIC_HGC = 4'd10;
  localparam logic [3:0] VIC_HGI = 4'd11;
  localparam logic [3:0] VIC_HRX = 4'd14;

  logic [13:0] ado_q, ado_d, addr_mux, addr_lg;
  logic        ado_oe_q, ado_oe_d;
  logic [7:0]  ref_cnt_q, ref_cnt_d;
  logic [7:0]  spr_ptr [8];
  logic [5:0]  spr_mc  [8];
  logic        frame_start;

  // Sprite 0 sits in the most significant slice of each flattened bus.
  for (genvar i = 0; i < 8; i++) begin : g_spr
    assign spr_ptr[i] = sprite_ptr_i[63-8*i -: 8];
    assign spr_mc[i]  = sprite_mc_i[47-6*i -: 6];
  end

  always_comb begin
    addr_lg = IDLE_ADDR;
    if (!idle) addr_lg = bmm ? {cb[2], vc, rc} : {cb, char_next[7:0], rc};
    // ECM clamps the char code to 64 entries, idle fetches included.
    if (ecm) addr_lg[10:9] = 2'b00;
  end

  always_comb begin
    addr_mux = IDLE_ADDR;
    case (cycle_type)
      VIC_HRC, VIC_HGC, VIC_HRX, VIC_HGI: addr_mux = {vm, vc};
      VIC_LG:                             addr_mux = addr_lg;
      VIC_LP:                             addr_mux = {vm, 7'h7F, sprite_cnt};
      VIC_HS1, VIC_LS2, VIC_HS3:          addr_mux = {spr_ptr[sprite_cnt], spr_mc[sprite_cnt]};
      VIC_LR:                             addr_mux = {6'h3F, ref_cnt_q};
      default:                            addr_mux = IDLE_ADDR;
    endcase
  end

  assign frame_start = (raster_line == 9'd0) && (cycle_num == 7'd0) && phi_phase_start_0;

  always_comb begin
    ado_d     = ado_q;
    ado_oe_d  = ado_oe_q;
    ref_cnt_d = ref_cnt_q;
    if (phi_phase_start_as) begin
      ado_d    = addr_mux;
      ado_oe_d = clk_phi ? !aec : 1'b1;
      if (cycle_type == VIC_LR) ref_cnt_d = ref_cnt_q - 8'd1;
    end
    // Frame-start reload takes priority over a coincident refresh decrement.
    if (frame_start) ref_cnt_d = REF_INIT;
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      ado_q     <= IDLE_ADDR;
      ado_oe_q  <= 1'b0;
      ref_cnt_q <= REF_INIT;
    end else begin
      ado_q     <= ado_d;
      ado_oe_q  <= ado_oe_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  assign ado     = ado_q;
  assign ado_oe  = ado_oe_q;
  assign ref_cnt = ref_cnt_q;

endmodule
